pwm_driver: RTL and testbench

PWM output stage directly downstream of the breathing-ramp generator. Takes its 32-bit level as a duty value and drives one LED pin with a pulse train of programmable period and prescale. Duty is double-buffered: it is loaded only at period boundaries, so the ramp can change mid-period without producing glitch pulses.

---
 rtl/pwm_driver.sv | 71 +++++++
 tb/tb_pwm_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_driver.sv
// PWM output stage: prescaled counter with a double-buffered, saturating duty compare.
// Duty is latched into the shadow register only at period wrap, or continuously while idle.
module pwm_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [WIDTH-1:0]      TOP,
    input  logic [31:0]           DUTY,
    input  logic                  INVERT,
    output logic                  PWM_OUT,
    output logic                  CYCLE_DONE,
    output logic [WIDTH:0]        DUTY_ACTIVE
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [WIDTH-1:0]      pwm_cnt;
    logic [WIDTH:0]        shadow;

    logic [WIDTH:0]        top_p1;
    logic [32:0]           top_p1_wide;
    logic [WIDTH:0]        duty_sat;
    logic                  tick;
    logic                  wrap;
    logic                  active;

    // Clamp in 33 bits so large ramp values saturate instead of aliasing after truncation.
    always_comb begin
        top_p1      = {1'b0, TOP} + (WIDTH+1)'(1);
        top_p1_wide = {{(32-WIDTH){1'b0}}, top_p1};
        duty_sat    = ({1'b0, DUTY} > top_p1_wide) ? top_p1 : DUTY[WIDTH:0];
    end

    always_comb begin
        tick   = EN && (pre_cnt >= PRESCALE);
        wrap   = tick && (pwm_cnt >= TOP);
        active = ({1'b0, pwm_cnt} < shadow);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            shadow     <= '0;
            PWM_OUT    <= 1'b0;
            CYCLE_DONE <= 1'b0;
        end else if (!EN) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            shadow     <= duty_sat;
            PWM_OUT    <= INVERT;
            CYCLE_DONE <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
            CYCLE_DONE <= wrap;
            PWM_OUT    <= active ^ INVERT;
            if (tick) begin
                pwm_cnt <= wrap ? '0 : pwm_cnt + WIDTH'(1);
            end
            if (wrap) begin
                shadow <= duty_sat;
            end
        end
    end

    assign DUTY_ACTIVE = shadow;

endmodule

// File: tb/tb_pwm_driver.sv
// Self-checking bench for pwm_driver: directed scenarios plus randomized stimulus
// compared every clock against a behavioural model built from integer arithmetic.
module tb_pwm_driver;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PRESCALE_W = 16;

    logic                  CLK;
    logic                  RST;
    logic                  EN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [WIDTH-1:0]      TOP;
    logic [31:0]           DUTY;
    logic                  INVERT;
    logic                  PWM_OUT;
    logic                  CYCLE_DONE;
    logic [WIDTH:0]        DUTY_ACTIVE;

    pwm_driver #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .PRESCALE    (PRESCALE),
        .TOP         (TOP),
        .DUTY        (DUTY),
        .INVERT      (INVERT),
        .PWM_OUT     (PWM_OUT),
        .CYCLE_DONE  (CYCLE_DONE),
        .DUTY_ACTIVE (DUTY_ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int hi     = 0;
    int dn     = 0;

    // Reference state: prescale phase, count within period, applied duty, registered pins.
    int m_pre, m_cnt, m_duty;
    bit m_out, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre  = 0;
        m_cnt  = 0;
        m_duty = 0;
        m_out  = 0;
        m_done = 0;
    endtask

    // Advance the model by one clock using the inputs present just before the edge.
    task automatic model_next();
        longint unsigned period = longint'(TOP) + 1;
        longint unsigned d      = DUTY;
        int              dsat   = int'((d > period) ? period : d);
        if (!EN) begin
            m_pre  = 0;
            m_cnt  = 0;
            m_duty = dsat;
            m_out  = INVERT;
            m_done = 0;
        end else begin
            bit ticked = (m_pre >= int'(PRESCALE));
            m_out  = (m_cnt < m_duty) ^ INVERT;
            m_done = ticked && (m_cnt >= int'(TOP));
            if (ticked) begin
                m_pre = 0;
                if (m_cnt >= int'(TOP)) begin
                    m_cnt  = 0;
                    m_duty = dsat;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_next();
            @(posedge CLK);
            #1;
            check("model", {21'b0, PWM_OUT, CYCLE_DONE, DUTY_ACTIVE},
                  {21'b0, m_out, m_done, 9'(m_duty)});
            hi += int'(PWM_OUT);
            dn += int'(CYCLE_DONE);
        end
    endtask

    task automatic idle_cfg(input int p, input int t, input logic [31:0] d, input logic inv);
        EN       = 1'b0;
        PRESCALE = PRESCALE_W'(p);
        TOP      = WIDTH'(t);
        DUTY     = d;
        INVERT   = inv;
        step(1);
    endtask

    initial begin
        RST      = 1'b1;
        EN       = 1'b0;
        PRESCALE = '0;
        TOP      = '0;
        DUTY     = '0;
        INVERT   = 1'b0;
        model_reset();
        #3;
        check("reset_state", {21'b0, PWM_OUT, CYCLE_DONE, DUTY_ACTIVE}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Basic duty: 3 of 10 high, wrap every 10 clocks.
        idle_cfg(0, 9, 32'd3, 1'b0);
        EN = 1'b1; hi = 0; dn = 0;
        step(30);
        check("basic_high", 32'(hi), 32'd9);
        check("basic_done", 32'(dn), 32'd3);

        // Double buffering: a mid-period duty change waits for the wrap.
        idle_cfg(0, 9, 32'd3, 1'b0);
        EN = 1'b1; hi = 0;
        step(5);
        DUTY = 32'd7;
        step(4);
        check("dbuf_hold", 32'(DUTY_ACTIVE), 32'd3);
        step(1);
        check("dbuf_load", 32'(DUTY_ACTIVE), 32'd7);
        check("dbuf_done", 32'(CYCLE_DONE), 32'd1);
        check("dbuf_old_high", 32'(hi), 32'd3);
        hi = 0;
        step(10);
        check("dbuf_new_high", 32'(hi), 32'd7);

        // Saturation at both ends.
        idle_cfg(0, 9, 32'h0000_1234, 1'b0);
        check("sat_active", 32'(DUTY_ACTIVE), 32'd10);
        EN = 1'b1; hi = 0;
        step(30);
        check("sat_full_high", 32'(hi), 32'd30);
        idle_cfg(0, 9, 32'd0, 1'b0);
        EN = 1'b1; hi = 0;
        step(30);
        check("sat_zero_high", 32'(hi), 32'd0);

        // Prescale: 4 clocks per count, 5 counts per period.
        idle_cfg(3, 4, 32'd2, 1'b0);
        EN = 1'b1; hi = 0; dn = 0;
        step(80);
        check("pre_high", 32'(hi), 32'd32);
        check("pre_done", 32'(dn), 32'd4);

        // Enable/invert: idle at the inactive level, then low 4 counts, high 6.
        idle_cfg(0, 9, 32'd4, 1'b1);
        step(1);
        check("idle_out", 32'(PWM_OUT), 32'd1);
        check("idle_done", 32'(CYCLE_DONE), 32'd0);
        EN = 1'b1; hi = 0;
        step(4);
        check("inv_low_phase", 32'(hi), 32'd0);
        step(6);
        check("inv_high_phase", 32'(hi), 32'd6);

        // TOP shrink below the current count wraps on the next tick.
        idle_cfg(0, 200, 32'd100, 1'b0);
        EN = 1'b1;
        step(50);
        TOP = WIDTH'(10);
        dn = 0;
        step(1);
        check("shrink_wrap", 32'(dn), 32'd1);
        step(3);

        // Asynchronous reset between edges.
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("async_rst", {21'b0, PWM_OUT, CYCLE_DONE, DUTY_ACTIVE}, 32'd0);
        RST = 1'b0;
        step(2);

        // Randomized stimulus against the model.
        for (int it = 0; it < 300; it++) begin
            EN       = ($urandom_range(0, 7) != 0);
            INVERT   = 1'($urandom_range(0, 1));
            PRESCALE = PRESCALE_W'($urandom_range(0, 3));
            TOP      = ($urandom_range(0, 15) == 0) ? WIDTH'(255) : WIDTH'($urandom_range(0, 20));
            DUTY     = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 25));
            step(int'($urandom_range(1, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
